// File: rtl/keypad_lock_if.sv
// keypad_lock_if: key event inputs and lock status outputs between keypad side and lock controller
interface keypad_lock_if #(
   parameter int CODE_LEN = 4
) ();
   logic                key_valid;
   logic [3:0]          key_code;
   logic                prog_req;
   logic [2:0]          state;
   logic                unlocked;
   logic [CODE_LEN-1:0] password_led;
   logic [3:0]          fail_count;
   logic                alarm;
   modport master (
      output key_valid, key_code, prog_req,
      input  state, unlocked, password_led, fail_count, alarm
   );
   modport slave (
      input  key_valid, key_code, prog_req,
      output state, unlocked, password_led, fail_count, alarm
   );
endinterface

// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl: code entry, relock, reprogramming and lockout FSM driven by decoded key events
module keypad_lock_ctrl #(
   parameter int                    CODE_LEN       = 4,
   parameter int                    MAX_TRIES      = 3,
   parameter int                    LOCKOUT_CYCLES = 1000,
   parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE   = 16'h1234
) (
   input logic         clk,
   input logic         reset,
   keypad_lock_if.slave bus
);
   localparam int W  = CODE_LEN * 4;
   localparam int CW = $clog2(CODE_LEN + 1);
   localparam int LW = LOCKOUT_CYCLES > 1 ? $clog2(LOCKOUT_CYCLES) : 1;
   typedef enum logic [2:0] {LOCKED = 3'd0, ENTRY = 3'd1, OPEN = 3'd2, PROGRAM = 3'd3, LOCKOUT = 3'd4} state_t;
   state_t              st, nxt_st;
   logic [W-1:0]        ent, nxt_ent, app_ent, code, nxt_code;
   logic [W+3:0]        shifted;
   logic [CW-1:0]       cnt, nxt_cnt, app_cnt;
   logic [3:0]          fail, nxt_fail, inc_fail;
   logic [LW-1:0]       lcnt, nxt_lcnt;
   logic [CODE_LEN-1:0] nxt_led;
   logic                is_dig, is_star, is_hash, full, clr;
   assign bus.state      = st;
   assign bus.fail_count = fail;
   // next-state, buffer, stored code and counters; the entry buffer is cleared on every state change except LOCKED->ENTRY
   always_comb begin
      nxt_st   = st;
      nxt_ent  = ent;
      nxt_cnt  = cnt;
      nxt_fail = fail;
      nxt_code = code;
      nxt_lcnt = lcnt;
      clr      = 1'b0;
      is_dig   = bus.key_valid && bus.key_code <= 4'd9;
      is_star  = bus.key_valid && bus.key_code == 4'd10;
      is_hash  = bus.key_valid && bus.key_code == 4'd11;
      full     = cnt == CW'(CODE_LEN);
      shifted  = {ent, bus.key_code};
      app_ent  = full ? ent : shifted[W-1:0];
      app_cnt  = full ? cnt : cnt + CW'(1);
      inc_fail = fail == 4'hf ? fail : fail + 4'd1;
      case (st)
         LOCKED: begin
            if (is_dig) begin
               nxt_st  = ENTRY;
               nxt_ent = app_ent;
               nxt_cnt = app_cnt;
            end
         end
         ENTRY: begin
            if (is_dig) begin
               nxt_ent = app_ent;
               nxt_cnt = app_cnt;
            end else if (is_star) begin
               nxt_st = LOCKED;
               clr    = 1'b1;
            end else if (is_hash) begin
               clr = 1'b1;
               if (full && ent == code) begin
                  nxt_st   = OPEN;
                  nxt_fail = 4'd0;
               end else begin
                  nxt_fail = inc_fail;
                  nxt_st   = 32'(inc_fail) == MAX_TRIES ? LOCKOUT : LOCKED;
                  nxt_lcnt = '0;
               end
            end
         end
         OPEN: begin
            if (is_hash) begin
               nxt_st = LOCKED;
               clr    = 1'b1;
            end else if (is_star && bus.prog_req) begin
               nxt_st = PROGRAM;
               clr    = 1'b1;
            end
         end
         PROGRAM: begin
            if (is_dig) begin
               nxt_ent = app_ent;
               nxt_cnt = app_cnt;
            end else if (is_star) begin
               nxt_st = OPEN;
               clr    = 1'b1;
            end else if (is_hash) begin
               clr = 1'b1;
               if (full) begin
                  nxt_code = ent;
                  nxt_st   = OPEN;
               end
            end
         end
         LOCKOUT: begin
            clr = 1'b1;
            if (lcnt == LW'(LOCKOUT_CYCLES - 1)) begin
               nxt_st   = LOCKED;
               nxt_fail = 4'd0;
               nxt_lcnt = '0;
            end else begin
               nxt_lcnt = lcnt + LW'(1);
            end
         end
         default: begin
            nxt_st = LOCKED;
            clr    = 1'b1;
         end
      endcase
      if (clr) begin
         nxt_ent = '0;
         nxt_cnt = '0;
      end
      for (int i = 0; i < CODE_LEN; i++) nxt_led[i] = 32'(nxt_cnt) > i;
   end
   // state, buffer, code and counter registers plus registered status outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st               <= LOCKED;
         ent              <= '0;
         cnt              <= '0;
         fail             <= '0;
         code             <= DEFAULT_CODE;
         lcnt             <= '0;
         bus.password_led <= '0;
         bus.unlocked     <= 1'b0;
         bus.alarm        <= 1'b0;
      end else begin
         st               <= nxt_st;
         ent              <= nxt_ent;
         cnt              <= nxt_cnt;
         fail             <= nxt_fail;
         code             <= nxt_code;
         lcnt             <= nxt_lcnt;
         bus.password_led <= nxt_led;
         bus.unlocked     <= nxt_st == OPEN || nxt_st == PROGRAM;
         bus.alarm        <= nxt_st == LOCKOUT;
      end
   end
endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// tb_keypad_lock_ctrl: scoreboard bench driving key sequences and checking all lock outputs every step
module tb_keypad_lock_ctrl;
   typedef struct {
      string tag;
      int    sel;
      int    val;
   } exp_t;
   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_bad = 0;
   exp_t sb[$];
   int   m_st, m_cnt, m_val, m_fail, m_code;
   keypad_lock_if #(.CODE_LEN(4)) bus ();
   keypad_lock_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input integer obs_v, input integer exp_v);
      n_vec++;
      if (obs_v !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (vector %0d)", tag, obs_v, exp_v, n_vec);
      end
   endtask
   function automatic integer obs(input int sel);
      case (sel)
         0:       return integer'(bus.state);
         1:       return integer'(bus.unlocked);
         2:       return integer'(bus.password_led);
         3:       return integer'(bus.fail_count);
         default: return integer'(bus.alarm);
      endcase
   endfunction
   task automatic model_reset();
      m_st = 0; m_cnt = 0; m_val = 0; m_fail = 0; m_code = 1234;
   endtask
   task automatic go(input int s);
      m_st = s; m_cnt = 0; m_val = 0;
   endtask
   task automatic app(input int k);
      if (m_cnt < 4) begin
         m_val = m_val * 10 + k;
         m_cnt++;
      end
   endtask
   task automatic model(input int k, input bit p);
      bit d = k <= 9;
      case (m_st)
         0: if (d) begin m_st = 1; m_val = k; m_cnt = 1; end
         1: begin
            if (d) app(k);
            else if (k == 10) go(0);
            else if (k == 11) begin
               if (m_cnt == 4 && m_val == m_code) begin
                  go(2);
                  m_fail = 0;
               end else begin
                  m_fail = m_fail < 15 ? m_fail + 1 : 15;
                  go(m_fail == 3 ? 4 : 0);
               end
            end
         end
         2: if (k == 11) go(0); else if (k == 10 && p) go(3);
         3: begin
            if (d) app(k);
            else if (k == 10) go(2);
            else if (k == 11) begin
               if (m_cnt == 4) begin
                  m_code = m_val;
                  go(2);
               end else go(3);
            end
         end
         default: ;
      endcase
   endtask
   task automatic expect_all();
      sb.push_back('{"state", 0, m_st});
      sb.push_back('{"unlocked", 1, int'(m_st == 2 || m_st == 3)});
      sb.push_back('{"password_led", 2, (1 << m_cnt) - 1});
      sb.push_back('{"fail_count", 3, m_fail});
      sb.push_back('{"alarm", 4, int'(m_st == 4)});
   endtask
   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.tag, obs(e.sel), e.val);
      end
   endtask
   task automatic step(input bit v, input int k, input bit p);
      if (v) model(k, p);
      expect_all();
      @(negedge clk);
      bus.key_valid = v;
      bus.key_code  = 4'(k);
      bus.prog_req  = p;
      @(posedge clk);
      #1;
      bus.key_valid = 1'b0;
      drain();
   endtask
   task automatic keys(input int a, input int b, input int c, input int d, input int e);
      step(1, a, 0); step(1, b, 0); step(1, c, 0); step(1, d, 0); step(1, e, 0);
   endtask
   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      expect_all();
      #1;
      drain();
      @(negedge clk);
      reset = 1'b0;
   endtask
   initial begin
      int n;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'd0;
      bus.prog_req  = 1'b0;
      reset = 1'b0;
      apply_reset();
      keys(1, 2, 3, 4, 11);
      step(1, 11, 0);
      keys(1, 2, 3, 5, 11);
      keys(1, 2, 3, 5, 11);
      keys(1, 2, 3, 5, 11);
      step(1, 1, 0); step(1, 11, 0); step(1, 10, 1);
      n = 0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.state == 3'd0) break;
      end
      chk("lockout_len", 3 + n, 1000);
      m_st = 0;
      m_fail = 0;
      step(0, 0, 0);
      step(1, 1, 0); step(1, 2, 0); step(1, 10, 0);
      step(1, 1, 0); step(1, 2, 0); step(1, 3, 0); step(1, 11, 0);
      keys(1, 2, 3, 4, 11);
      step(1, 10, 0);
      step(1, 10, 1);
      step(1, 5, 0); step(1, 11, 0);
      keys(9, 8, 7, 6, 11);
      step(1, 11, 0);
      keys(1, 2, 3, 4, 11);
      keys(9, 8, 7, 6, 11);
      step(1, 10, 1);
      step(1, 1, 0); step(1, 10, 0);
      step(1, 10, 1);
      step(1, 5, 0); step(1, 5, 0);
      apply_reset();
      keys(9, 8, 7, 6, 11);
      keys(1, 2, 3, 4, 11);
      step(1, 11, 0);
      step(1, 1, 0); step(1, 12, 0); step(1, 2, 0); step(1, 3, 0);
      step(1, 4, 0); step(1, 5, 0); step(1, 6, 0); step(1, 15, 0);
      step(1, 11, 0);
      step(1, 13, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
